// File: rtl/bch_31_encoder.sv
// Systematic BCH(31,21) t=2 encoder: bit-serial LFSR parity generation over the
// generator x^10+x^9+x^8+x^6+x^5+x^3+1, with valid/ready on both sides.
module bch_31_encoder #(
  parameter int          K        = 21,
  parameter int          N        = 31,
  parameter logic [10:0] GEN_POLY = 11'h769
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [K-1:0] msg_i,
  input  logic         msg_valid_i,
  output logic         msg_ready_o,
  output logic [N-1:0] codeword_o,
  output logic         cw_valid_o,
  input  logic         cw_ready_i,
  output logic         busy_o,
  output logic [1:0]   dbg_state
);

  // Handshake rule for both ports: a transfer happens on a rising edge where
  // valid and ready are both high; valid, once raised, is held with stable data
  // until that edge. Both ready/valid outputs are pure decodes of the state reg.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [K-1:0]   msg_q, msg_n;
  logic [9:0]     par_q, par_n;
  logic [4:0]     cnt_q, cnt_n;
  logic [N-1:0]   cw_q, cw_n;
  logic           fb;
  logic [9:0]     par_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      msg_q <= '0;
      par_q <= '0;
      cnt_q <= '0;
      cw_q  <= '0;
    end else begin
      state <= state_n;
      msg_q <= msg_n;
      par_q <= par_n;
      cnt_q <= cnt_n;
      cw_q  <= cw_n;
    end
  end

  // Division step: feed the current message bit (MSB first) into the remainder.
  assign fb        = msg_q[cnt_q] ^ par_q[9];
  assign par_shift = {par_q[8:0], 1'b0} ^ (fb ? GEN_POLY[9:0] : 10'h000);

  always_comb begin
    state_n = state;
    msg_n   = msg_q;
    par_n   = par_q;
    cnt_n   = cnt_q;
    cw_n    = cw_q;
    case (state)
      IDLE: begin
        if (msg_valid_i) begin
          msg_n   = msg_i;
          par_n   = '0;
          cnt_n   = 5'(K - 1);
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        par_n = par_shift;
        if (cnt_q == 5'd0) begin
          cw_n    = {msg_q, par_shift};
          state_n = OUT;
        end else begin
          cnt_n = cnt_q - 5'd1;
        end
      end
      OUT: begin
        if (cw_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign msg_ready_o = (state == IDLE);
  assign cw_valid_o  = (state == OUT);
  assign busy_o      = (state == SHIFT) || (state == OUT);
  assign codeword_o  = cw_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_bch_31_encoder.sv
// Bench for bch_31_encoder: drivers push expected codewords at accept time, an
// independent monitor pops and compares whenever a codeword is presented.
module tb_bch_31_encoder;

  logic        clk;
  logic        rst;
  logic [20:0] msg_i;
  logic        msg_valid_i;
  logic        msg_ready_o;
  logic [30:0] codeword_o;
  logic        cw_valid_o;
  logic        cw_ready_i;
  logic        busy_o;
  logic [1:0]  dbg_state;

  logic [30:0] exp_q[$];
  int          n_cmp;
  int          n_bad;
  logic [30:0] last_cw;

  bch_31_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .msg_i       (msg_i),
    .msg_valid_i (msg_valid_i),
    .msg_ready_o (msg_ready_o),
    .codeword_o  (codeword_o),
    .cw_valid_o  (cw_valid_o),
    .cw_ready_i  (cw_ready_i),
    .busy_o      (busy_o),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference codeword by polynomial long division of msg(x)*x^10 by g(x).
  function automatic logic [30:0] ref_cw(input logic [20:0] m);
    logic [30:0] d;
    logic [30:0] g;
    d = {m, 10'h000};
    for (int i = 30; i >= 10; i--) begin
      if (d[i]) begin
        g = 31'h769 << (i - 10);
        d = d ^ g;
      end
    end
    return {m, d[9:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_msg_ready"}, 32'(msg_ready_o), 32'd1);
    chk({tag, "_cw_valid"},  32'(cw_valid_o),  32'd0);
    chk({tag, "_codeword"},  32'(codeword_o),  32'd0);
    chk({tag, "_busy"},      32'(busy_o),      32'd0);
  endtask

  // driver: present a message and hold it until the accepting edge
  task automatic accept(input logic [20:0] m, input logic [30:0] exp_cw);
    int w;
    msg_i       = m;
    msg_valid_i = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!msg_ready_o && w < 100);
    if (!msg_ready_o) begin
      chk("accept_timeout", 32'(msg_ready_o), 32'd1);
      msg_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(exp_cw);
    #1;
    msg_valid_i = 1'b0;
  endtask

  // wait for cw_valid_o, counting edges since acceptance; optionally jam inputs
  task automatic wait_cw(input bit noise);
    int lat;
    lat = 0;
    while (!cw_valid_o && lat < 100) begin
      if (noise) begin
        msg_valid_i = 1'($urandom_range(0, 1));
        msg_i       = 21'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
      if (noise && !cw_valid_o) chk("shift_ready_low", 32'(msg_ready_o), 32'd0);
    end
    chk("latency", 32'(lat), 32'd21);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && cw_valid_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_cw: got 0x%0h expected none at %0t", codeword_o, $time);
      end else begin
        chk("codeword", 32'(codeword_o), 32'(exp_q[0]));
        if (cw_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    msg_i       = '0;
    msg_valid_i = 1'b0;
    cw_ready_i  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;

    // all-zero message, then handshake returns to IDLE in one edge
    accept(21'h000000, 31'h00000000);
    wait_cw(1'b0);
    @(posedge clk);
    #1;
    chk("t1_ready_after", 32'(msg_ready_o), 32'd1);
    chk("t1_valid_after", 32'(cw_valid_o),  32'd0);

    // single-bit messages: g(x) itself and (x+1)*g(x)
    accept(21'h000001, 31'h00000769);
    wait_cw(1'b0);
    @(posedge clk);
    #1;
    chk("t2_cw_hold_idle", 32'(codeword_o), 32'h00000769);
    accept(21'h000002, 31'h000009BB);
    wait_cw(1'b0);
    @(posedge clk);
    #1;

    // stall in OUT with input noise during SHIFT and OUT
    cw_ready_i = 1'b0;
    accept(21'h000001, 31'h00000769);
    wait_cw(1'b1);
    repeat (10) begin
      msg_valid_i = 1'($urandom_range(0, 1));
      msg_i       = 21'($urandom);
      @(posedge clk);
      #1;
      chk("t4_stall_ready", 32'(msg_ready_o), 32'd0);
      chk("t4_stall_valid", 32'(cw_valid_o),  32'd1);
    end
    msg_valid_i = 1'b0;
    cw_ready_i  = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_idle_ready", 32'(msg_ready_o), 32'd1);
    chk("t4_cw_kept",    32'(codeword_o),  32'h00000769);

    // reset 8 cycles into SHIFT discards the word
    accept(21'h000001, 31'h00000769);
    repeat (8) @(posedge clk);
    #1;
    chk("t5_busy_mid", 32'(busy_o), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("t5_reset");
    rst = 1'b0;
    exp_q.delete();
    accept(21'h000002, 31'h000009BB);
    wait_cw(1'b0);
    @(posedge clk);
    #1;

    // back-to-back random messages against the long-division reference
    for (int i = 0; i < 1000; i++) begin
      logic [20:0] m;
      m = 21'($urandom_range(0, 21'h1FFFFF));
      accept(m, ref_cw(m));
      wait_cw(1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
